avsd_sar_adc_ctrl: RTL and testbench

Successive-approximation (SAR) controller that converts an analog input to a WIDTH-bit code, the analog-to-digital counterpart of the 10-bit DAC path.
- Drives a trial code into the DAC and reads back a 1-bit comparator (VIN vs DAC output), resolving one bit per step, MSB first.
- Sits beside the DAC/comparator macro. Presents the result to the rvmyth core side with a START/BUSY/DONE handshake.

---
 rtl/avsd_sar_adc_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_avsd_sar_adc_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/avsd_sar_adc_ctrl.sv
// ---------------------------------------------------------------------------
// avsd_sar_adc_ctrl
//
// Successive-approximation ADC controller. It tracks the analog input for
// SAMPLE_CYCLES, then resolves one result bit per step, MSB first. Each step
// drives a trial code on DAC_D, waits SETTLE_CYCLES, and then samples the
// comparator for one cycle.
//
// Ports:
//   CLK     system clock; all logic is on the rising edge
//   RST_N   synchronous, active-low reset
//   START   conversion request, sampled only while idle
//   COMP    comparator output, 1 when VIN >= DAC output (already synchronous)
//   DAC_D   trial code to the DAC (0 while idle or tracking)
//   SAMPLE  track/hold control, 1 = track
//   BUSY    high from the first cycle after START until the DONE cycle
//   DONE    one-cycle pulse, DOUT holds the new result
//   DOUT    last completed conversion result
//
// Optional build macro AVSD_SAR_ADC_AVG_EN:
//   Each START runs four conversions back to back. Their results are summed
//   in a WIDTH+2 bit accumulator, and DOUT receives the truncated average
//   (sum >> 2). DONE pulses only once, after the fourth conversion.
// ---------------------------------------------------------------------------
module avsd_sar_adc_ctrl #(
  parameter int WIDTH         = 10,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             COMP,
  output logic [WIDTH-1:0] DAC_D,
  output logic             SAMPLE,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DOUT
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRACK,
    S_SETTLE,
    S_DECIDE,
    S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   dout_q, dout_d;

  // res_q holds only the bits that have already been decided. The bit under
  // test is OR-ed in here, so a trial code never has a bit below idx_q set.
  logic [WIDTH-1:0]   bit_mask;
  logic [WIDTH-1:0]   trial;
  logic [WIDTH-1:0]   res_kept;

  assign bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << idx_q;
  assign trial    = res_q | bit_mask;
  assign res_kept = COMP ? trial : res_q;

`ifdef AVSD_SAR_ADC_AVG_EN
  logic [WIDTH+1:0]   acc_q, acc_d;
  logic [1:0]         conv_q, conv_d;
  logic [WIDTH+1:0]   acc_sum;

  assign acc_sum = acc_q + {2'b00, res_kept};
`endif

  // State register
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is assigned with <= so that every flop samples
    // the values from before the edge, regardless of statement order.
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      dout_q  <= '0;
`ifdef AVSD_SAR_ADC_AVG_EN
      acc_q   <= '0;
      conv_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
`ifdef AVSD_SAR_ADC_AVG_EN
      acc_q   <= acc_d;
      conv_q  <= conv_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    // NOTE: every signal gets its hold value first. Any path through the
    // case statement that leaves it unassigned therefore cannot infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    res_d   = res_q;
    dout_d  = dout_q;
`ifdef AVSD_SAR_ADC_AVG_EN
    acc_d   = acc_q;
    conv_d  = conv_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_TRACK;
          res_d   = '0;
          cnt_d   = CNT_W'(SAMPLE_CYCLES - 1);
        end
      end
      S_TRACK: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          idx_d   = IDX_W'(WIDTH - 1);
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_DECIDE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DECIDE: begin
        res_d = res_kept;
        if (idx_q != '0) begin
          state_d = S_SETTLE;
          idx_d   = idx_q - IDX_W'(1);
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
`ifdef AVSD_SAR_ADC_AVG_EN
          if (conv_q == 2'd3) begin
            state_d = S_FINISH;
            dout_d  = acc_sum[WIDTH+1:2];
            acc_d   = '0;
            conv_d  = '0;
          end else begin
            // Go straight back to tracking. Intermediate results are not
            // reported, so no FINISH or IDLE cycle is spent between them.
            state_d = S_TRACK;
            acc_d   = acc_sum;
            conv_d  = conv_q + 2'd1;
            res_d   = '0;
            cnt_d   = CNT_W'(SAMPLE_CYCLES - 1);
          end
`else
          // DOUT is loaded on entry to FINISH, so it is already valid in the
          // cycle where DONE is high.
          state_d = S_FINISH;
          dout_d  = res_kept;
`endif
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    DAC_D  = '0;
    SAMPLE = 1'b0;
    DONE   = 1'b0;
    BUSY   = (state_q != S_IDLE);
    unique case (state_q)
      S_TRACK:           SAMPLE = 1'b1;
      S_SETTLE, S_DECIDE: DAC_D  = trial;
      S_FINISH:          DONE   = 1'b1;
      default:           ;
    endcase
  end

  assign DOUT = dout_q;

endmodule

// File: tb/tb_avsd_sar_adc_ctrl.sv
module tb_avsd_sar_adc_ctrl;

  localparam int W      = 10;
  localparam int SAMP   = 4;
  localparam int SETT   = 2;
  localparam int SINGLE = SAMP + W * (SETT + 1) + 1;   // 35 with defaults
`ifdef AVSD_SAR_ADC_AVG_EN
  localparam int LAT    = 4 * SINGLE - 3;
`else
  localparam int LAT    = SINGLE;
`endif

  typedef struct {
    int vin;
    int exp_dout;
    bit extra_start;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         comp;
  logic [W-1:0] dac_d;
  logic         sample;
  logic         busy;
  logic         done;
  logic [W-1:0] dout;

  int n_tests = 0;
  int n_fail  = 0;
  int vin_code;
  int exp_q[$];
  int exp_pop;
  vec_t vecs[5];

  always #5 clk = ~clk;

  // Ideal comparator: VIN >= DAC output
  assign comp = (vin_code >= int'(dac_d));

  avsd_sar_adc_ctrl #(
    .WIDTH(W), .SAMPLE_CYCLES(SAMP), .SETTLE_CYCLES(SETT)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .COMP(comp),
    .DAC_D(dac_d), .SAMPLE(sample), .BUSY(busy), .DONE(done), .DOUT(dout)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every DONE must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_pop = exp_q.pop_front();
        check("dout_at_done", int'(dout), exp_pop);
      end
    end
  end

  // A single conversion started with a one-cycle START pulse. The edge that
  // accepts START is cycle 0, and cycle c is sampled at the following negedge.
  task automatic run_conv(input int vin, input int exp, input bit extra_start);
    int done_c;
    int decided;
    int trial_exp;
    int k;
    vin_code = vin;
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(exp);
    done_c  = -1;
    decided = 0;
    for (int c = 1; c <= LAT + 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (extra_start && (c == 5 || c == 20)) start = 1'b1;
      if (extra_start && (c == 6 || c == 21)) start = 1'b0;
      if (c == 1) begin
        check("busy_c1", int'(busy), 1);
        check("sample_c1", int'(sample), 1);
      end
      if (c == SAMP) check("sample_last", int'(sample), 1);
      if (c == SAMP + 1) begin
        check("sample_off", int'(sample), 0);
        check("first_trial", int'(dac_d), 1 << (W - 1));
      end
      // The DECIDE cycle of bit k: an independent binary-search reference.
      if (c > SAMP && c <= SAMP + W * (SETT + 1) && ((c - SAMP - 1) % (SETT + 1)) == SETT) begin
        k         = (c - SAMP - 1) / (SETT + 1);
        trial_exp = decided | (1 << (W - 1 - k));
        check($sformatf("trial_bit%0d_vin%0d", W - 1 - k, vin), int'(dac_d), trial_exp);
        if (vin >= trial_exp) decided = trial_exp;
      end
      if (done && done_c < 0) done_c = c;
      if (done_c > 0 && c == done_c + 1) check("busy_after_done", int'(busy), 0);
      if (done_c > 0 && c == done_c + 2) break;
    end
    check($sformatf("done_cycle_vin%0d", vin), done_c, LAT);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_n;
    int done_c1;
    int done_c2;
    int busy_drops;
    int sched[4];
    int n_track;
    logic prev_s;

    vecs[0] = '{vin: 512,  exp_dout: 512,  extra_start: 1'b0};
    vecs[1] = '{vin: 0,    exp_dout: 0,    extra_start: 1'b0};
    vecs[2] = '{vin: 1023, exp_dout: 1023, extra_start: 1'b0};
    vecs[3] = '{vin: 700,  exp_dout: 700,  extra_start: 1'b0};
    vecs[4] = '{vin: 300,  exp_dout: 300,  extra_start: 1'b1};

    rst_n    = 1'b0;
    start    = 1'b0;
    vin_code = 0;
    repeat (3) @(negedge clk);
    check("rst_dout", int'(dout), 0);
    check("rst_dac_d", int'(dac_d), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sample", int'(sample), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_conv(vecs[i].vin, vecs[i].exp_dout, vecs[i].extra_start);

    // Reset in cycle 15 aborts the conversion. No DONE follows.
    vin_code = 555;
    @(negedge clk);
    start  = 1'b1;
    done_n = 0;
    for (int c = 1; c <= LAT + 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 15) rst_n = 1'b0;
      if (c == 16) begin
        check("abort_busy", int'(busy), 0);
        check("abort_dout", int'(dout), 0);
        check("abort_dac_d", int'(dac_d), 0);
        rst_n = 1'b1;
      end
      if (done) done_n++;
    end
    check("abort_no_done", done_n, 0);
    run_conv(100, 100, 1'b0);

    // START held high: the second conversion starts in the IDLE cycle that
    // follows the first DONE.
    vin_code = 400;
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(400);
    exp_q.push_back(400);
    done_c1 = -1;
    done_c2 = -1;
    for (int c = 1; c <= 2 * LAT + 20; c++) begin
      @(negedge clk);
      if (c == LAT + 1) check("b2b_idle_gap", int'(busy), 0);
      if (c == LAT + 2) start = 1'b0;
      if (done) begin
        if (done_c1 < 0) done_c1 = c;
        else if (done_c2 < 0) done_c2 = c;
      end
    end
    check("b2b_done1", done_c1, LAT);
    check("b2b_done2", done_c2, 2 * LAT + 1);

`ifdef AVSD_SAR_ADC_AVG_EN
    // Averaging: the input changes for each of the four internal conversions.
    sched      = '{100, 101, 102, 104};
    n_track    = 0;
    busy_drops = 0;
    done_c1    = -1;
    prev_s     = 1'b0;
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(101);   // (100+101+102+104) >> 2
    for (int c = 1; c <= LAT + 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (sample && !prev_s && n_track < 4) begin
        vin_code = sched[n_track];
        n_track++;
      end
      prev_s = sample;
      if (c <= LAT && !busy) busy_drops++;
      if (done && done_c1 < 0) done_c1 = c;
    end
    check("avg_busy_continuous", busy_drops, 0);
    check("avg_done_cycle", done_c1, LAT);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
